// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB peripheral slave: FSM state encoding,
// register-file depth and the read value returned for out-of-window addresses.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int          DEPTH     = 16;
  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_prot_fsm.sv
// APB transfer sequencer: tracks IDLE/SETUP/ACCESS, captures the setup-phase
// address/control/data and flags protocol violations as a registered pulse.
module apb_prot_fsm
  import apb_slave_pkg::*;
(
  input  logic        Pclk,
  input  logic        Preset,
  input  logic        sel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic        setup_load,
  output logic        access_done,
  output logic        cap_write,
  output logic [31:0] cap_addr,
  output logic [31:0] cap_wdata,
  output logic        prot_err
);

  apb_state_e state, state_next;
  logic       err_next;

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    err_next    = 1'b0;
    setup_load  = 1'b0;
    access_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel && !Penable) begin
          state_next = SETUP;
          setup_load = 1'b1;
        end else if (!sel && Penable) begin
          err_next = 1'b1;
        end
      end
      SETUP: begin
        if (sel && Penable) begin
          state_next  = ACCESS;
          access_done = 1'b1;
          // The transfer completes with the captured values even on mismatch.
          if (Paddr != cap_addr || Pwrite != cap_write || Pwdata != cap_wdata)
            err_next = 1'b1;
        end else begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_next = IDLE;
        end else if (!Penable) begin
          state_next = SETUP;
          setup_load = 1'b1;
        end else begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state     <= IDLE;
      prot_err  <= 1'b0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      state    <= state_next;
      prot_err <= err_next;
      if (setup_load) begin
        cap_write <= Pwrite;
        cap_addr  <= Paddr;
        cap_wdata <= Pwdata;
      end
    end
  end

endmodule

// File: rtl/apb_periph_slave.sv
// Zero-wait-state APB slave with a 16 x 32-bit register window, saturating
// transfer counters and protocol-violation reporting.
module apb_periph_slave
  import apb_slave_pkg::*;
#(
  parameter int unsigned SEL_IDX   = 0,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        Pclk,
  input  logic        Preset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        prot_err,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  logic [31:0] mem [DEPTH];

  logic             sel;
  logic             setup_load;
  logic             access_done;
  logic             cap_write;
  logic [31:0]      cap_addr;
  logic [31:0]      cap_wdata;
  logic             rd_hit;
  logic             wr_hit;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             unused_sel_bits;

  assign sel             = Pselx[SEL_IDX];
  assign unused_sel_bits = ^Pselx;

  // Reads decode the live setup-phase address; writes use the captured one.
  assign rd_hit = (Paddr[31:6] == BASE_ADDR[31:6]);
  assign wr_hit = (cap_addr[31:6] == BASE_ADDR[31:6]);
  assign rd_idx = Paddr[5:2];
  assign wr_idx = cap_addr[5:2];

  apb_prot_fsm u_fsm (
    .Pclk        (Pclk),
    .Preset      (Preset),
    .sel         (sel),
    .Penable     (Penable),
    .Pwrite      (Pwrite),
    .Paddr       (Paddr),
    .Pwdata      (Pwdata),
    .setup_load  (setup_load),
    .access_done (access_done),
    .cap_write   (cap_write),
    .cap_addr    (cap_addr),
    .cap_wdata   (cap_wdata),
    .prot_err    (prot_err)
  );

  // NOTE: the register file is cleared by reset, so it is built from flops
  // rather than a RAM macro; that is the price of a defined power-up state.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      Prdata   <= '0;
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (setup_load && !Pwrite)
        Prdata <= rd_hit ? mem[rd_idx] : DEAD_BEEF;
      if (access_done) begin
        if (cap_write) begin
          if (wr_hit) mem[wr_idx] <= cap_wdata;
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else if (rd_count != 16'hFFFF) begin
          rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_periph_slave.sv
// Directed bench for apb_periph_slave: a cycle-by-cycle vector table followed
// by hand sequences for mid-transfer reset and read-counter saturation.
module tb_apb_periph_slave;
  import apb_slave_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        Pclk;
  logic        Preset;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        prot_err;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  apb_periph_slave #(.SEL_IDX(0), .BASE_ADDR(BASE)) dut (
    .Pclk     (Pclk),
    .Preset   (Preset),
    .Pselx    (Pselx),
    .Penable  (Penable),
    .Pwrite   (Pwrite),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .Prdata   (Prdata),
    .prot_err (prot_err),
    .wr_count (wr_count),
    .rd_count (rd_count)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  typedef struct {
    logic [2:0]  psel;
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [15:0] exp_wr;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t        vecs[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_mem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive inputs, let the edge happen, sample 1 ns later.
  task automatic bus(input logic [2:0] ps, input logic en, input logic wr,
                     input logic [31:0] a, input logic [31:0] d);
    Pselx   = ps;
    Penable = en;
    Pwrite  = wr;
    Paddr   = a;
    Pwdata  = d;
    @(posedge Pclk);
    #1;
  endtask

  task automatic add(input logic [2:0] ps, input logic en, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] er, input logic ee,
                     input logic [15:0] ew, input logic [15:0] erd);
    vec_t v;
    v.psel = ps; v.en = en; v.wr = wr; v.addr = a; v.wdata = d;
    v.exp_rdata = er; v.exp_err = ee; v.exp_wr = ew; v.exp_rd = erd;
    vecs.push_back(v);
  endtask

  task automatic do_read(input logic [31:0] a);
    bus(3'b001, 1'b0, 1'b0, a, 32'h0);
    bus(3'b001, 1'b1, 1'b0, a, 32'h0);
  endtask

  initial begin
    //   psel    en   wr   addr          wdata          Prdata         err  wr  rd
    // Write then read of BASE+0x08.
    add(3'b001, 0, 1, BASE + 32'h08, 32'h1234_5678, 32'h0,         0, 0, 0);
    add(3'b001, 1, 1, BASE + 32'h08, 32'h1234_5678, 32'h0,         0, 1, 0);
    add(3'b001, 0, 0, BASE + 32'h08, 32'h0,         32'h1234_5678, 0, 1, 0);
    add(3'b001, 1, 0, BASE + 32'h08, 32'h0,         32'h1234_5678, 0, 1, 1);
    add(3'b000, 0, 0, 32'h0,         32'h0,         32'h1234_5678, 0, 1, 1);
    // Back-to-back write then read of BASE+0x3C.
    add(3'b001, 0, 1, BASE + 32'h3C, 32'hA5A5_A5A5, 32'h1234_5678, 0, 1, 1);
    add(3'b001, 1, 1, BASE + 32'h3C, 32'hA5A5_A5A5, 32'h1234_5678, 0, 2, 1);
    add(3'b001, 0, 0, BASE + 32'h3C, 32'h0,         32'hA5A5_A5A5, 0, 2, 1);
    add(3'b001, 1, 0, BASE + 32'h3C, 32'h0,         32'hA5A5_A5A5, 0, 2, 2);
    add(3'b100, 0, 0, 32'h0,         32'h0,         32'hA5A5_A5A5, 0, 2, 2);
    // Out-of-range read and write at 0x10.
    add(3'b001, 0, 0, 32'h0000_0010, 32'h0,         DEAD_BEEF,     0, 2, 2);
    add(3'b001, 1, 0, 32'h0000_0010, 32'h0,         DEAD_BEEF,     0, 2, 3);
    add(3'b001, 0, 1, 32'h0000_0010, 32'hFFFF_FFFF, DEAD_BEEF,     0, 2, 3);
    add(3'b001, 1, 1, 32'h0000_0010, 32'hFFFF_FFFF, DEAD_BEEF,     0, 3, 3);
    add(3'b010, 0, 0, 32'h0,         32'h0,         DEAD_BEEF,     0, 3, 3);
    // Penable without select in IDLE.
    add(3'b110, 1, 0, 32'h0,         32'h0,         DEAD_BEEF,     1, 3, 3);
    add(3'b000, 0, 0, 32'h0,         32'h0,         DEAD_BEEF,     0, 3, 3);
    // Address changed between SETUP and ACCESS: write lands at 0x18.
    add(3'b001, 0, 1, BASE + 32'h18, 32'hCAFE_0001, DEAD_BEEF,     0, 3, 3);
    add(3'b001, 1, 1, BASE + 32'h1C, 32'hCAFE_0001, DEAD_BEEF,     1, 4, 3);
    add(3'b000, 0, 0, 32'h0,         32'h0,         DEAD_BEEF,     0, 4, 3);
    add(3'b001, 0, 0, BASE + 32'h18, 32'h0,         32'hCAFE_0001, 0, 4, 3);
    add(3'b001, 1, 0, BASE + 32'h18, 32'h0,         32'hCAFE_0001, 0, 4, 4);
    add(3'b000, 0, 0, 32'h0,         32'h0,         32'hCAFE_0001, 0, 4, 4);
    add(3'b001, 0, 0, BASE + 32'h1C, 32'h0,         32'h0,         0, 4, 4);
    add(3'b001, 1, 0, BASE + 32'h1C, 32'h0,         32'h0,         0, 4, 5);
    add(3'b000, 0, 0, 32'h0,         32'h0,         32'h0,         0, 4, 5);
    // Second SETUP cycle instead of ACCESS: abort with error, no count.
    add(3'b001, 0, 0, BASE,          32'h0,         32'h0,         0, 4, 5);
    add(3'b001, 0, 0, BASE,          32'h0,         32'h0,         1, 4, 5);
    add(3'b000, 0, 0, 32'h0,         32'h0,         32'h0,         0, 4, 5);
    // ACCESS held for a second cycle: error, counted once.
    add(3'b001, 0, 1, BASE,          32'h0000_0007, 32'h0,         0, 4, 5);
    add(3'b001, 1, 1, BASE,          32'h0000_0007, 32'h0,         0, 5, 5);
    add(3'b001, 1, 1, BASE,          32'h0000_0007, 32'h0,         1, 5, 5);
    add(3'b000, 0, 0, 32'h0,         32'h0,         32'h0,         0, 5, 5);
    add(3'b001, 0, 0, BASE,          32'h0,         32'h0000_0007, 0, 5, 5);
    add(3'b001, 1, 0, BASE,          32'h0,         32'h0000_0007, 0, 5, 6);
    add(3'b000, 0, 0, 32'h0,         32'h0,         32'h0000_0007, 0, 5, 6);

    for (int k = 0; k < DEPTH; k++) exp_mem[k] = 32'h0;
    exp_mem[0]  = 32'h0000_0007;
    exp_mem[2]  = 32'h1234_5678;
    exp_mem[6]  = 32'hCAFE_0001;
    exp_mem[15] = 32'hA5A5_A5A5;

    // Reset
    Preset = 1'b1;
    bus(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    bus(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    check("reset Prdata",   Prdata,          32'h0);
    check("reset prot_err", 32'(prot_err),   32'h0);
    check("reset wr_count", 32'(wr_count),   32'h0);
    check("reset rd_count", 32'(rd_count),   32'h0);
    check("reset state",    32'(dut.u_fsm.state), 32'(IDLE));
    Preset = 1'b0;

    foreach (vecs[i]) begin
      bus(vecs[i].psel, vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d Prdata", i),   Prdata,          vecs[i].exp_rdata);
      check($sformatf("v%0d prot_err", i), 32'(prot_err),   32'(vecs[i].exp_err));
      check($sformatf("v%0d wr_count", i), 32'(wr_count),   32'(vecs[i].exp_wr));
      check($sformatf("v%0d rd_count", i), 32'(rd_count),   32'(vecs[i].exp_rd));
    end

    for (int k = 0; k < DEPTH; k++)
      check($sformatf("mem[%0d]", k), dut.mem[k], exp_mem[k]);

    // Reset during the ACCESS cycle of a write to BASE+0x04.
    bus(3'b001, 1'b0, 1'b1, BASE + 32'h04, 32'h1111_2222);
    Preset = 1'b1;
    bus(3'b001, 1'b1, 1'b1, BASE + 32'h04, 32'h1111_2222);
    Preset = 1'b0;
    check("midreset mem[1]",   dut.mem[1],             32'h0);
    check("midreset wr_count", 32'(wr_count),          32'h0);
    check("midreset rd_count", 32'(rd_count),          32'h0);
    check("midreset state",    32'(dut.u_fsm.state),   32'(IDLE));
    bus(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    check("midreset no err",   32'(prot_err),          32'h0);
    check("midreset Prdata",   Prdata,                 32'h0);

    // Read-counter saturation: 65,537 back-to-back reads.
    for (int n = 0; n < 65534; n++) do_read(BASE + 32'h08);
    check("rd_count 65534",     32'(rd_count), 32'h0000_FFFE);
    do_read(BASE + 32'h08);
    check("rd_count 65535",     32'(rd_count), 32'h0000_FFFF);
    do_read(BASE + 32'h08);
    do_read(BASE + 32'h08);
    check("rd_count saturated", 32'(rd_count), 32'h0000_FFFF);
    check("wr_count after reads", 32'(wr_count), 32'h0);
    check("Prdata after reads", Prdata, 32'h0);
    check("no err after reads", 32'(prot_err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
